prog_loader: RTL and testbench

- Writer side of the program RAM interface: accepts a framed byte stream from a host link and writes 16-bit instruction words into program RAM port b.
- The control unit fetches from port a, so this block holds it stalled while loading.
- Sits between the host byte receiver (valid/ready) and program RAM port b; drives the page, address, data and write-enable for that port.
- Reports completion and checksum status to status indicators.

---
 rtl/prog_loader.sv | 139 +++++++++++++
 tb/tb_prog_loader.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Program RAM port-b writer: parses SYNC/page/addr/count/data/checksum frames from the
// host byte link and writes 16-bit instruction words, holding the CPU while loading.
module prog_loader #(
    parameter logic [7:0]  SYNC   = 8'hA5,
    parameter int unsigned PAGE_W = 2,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [PAGE_W-1:0] prog_page,
    output logic [ADDR_W-1:0] prog_addr,
    output logic [15:0]       prog_data,
    output logic              prog_we,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    typedef enum logic [3:0] {
        IDLE,
        PAGE,
        ADDR,
        COUNT,
        DHI,
        DLO,
        WRITE,
        CSUM,
        FAIL
    } state_t;

    state_t     state;
    logic [7:0] sum;
    logic [7:0] cnt;
    logic [7:0] dhi;
    logic       xfer;
    logic       is_sync;

    assign xfer    = rx_valid & rx_ready;
    assign is_sync = (rx_data == SYNC);

    // Frame parser; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            rx_ready  <= 1'b0;
            prog_page <= '0;
            prog_addr <= '0;
            prog_data <= '0;
            prog_we   <= 1'b0;
            cpu_hold  <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            sum       <= '0;
            cnt       <= '0;
            dhi       <= '0;
        end else begin
            prog_we  <= 1'b0;
            rx_ready <= 1'b1;
            case (state)
                IDLE, FAIL: begin
                    if (xfer && is_sync) begin
                        done     <= 1'b0;
                        err      <= 1'b0;
                        sum      <= '0;
                        cpu_hold <= 1'b1;
                        state    <= PAGE;
                    end
                end
                PAGE: begin
                    if (xfer) begin
                        if (rx_data[7:PAGE_W] != '0) begin
                            err   <= 1'b1;
                            state <= FAIL;
                        end else begin
                            prog_page <= rx_data[PAGE_W-1:0];
                            sum       <= sum + rx_data;
                            state     <= ADDR;
                        end
                    end
                end
                ADDR: begin
                    if (xfer) begin
                        prog_addr <= ADDR_W'(rx_data);
                        sum       <= sum + rx_data;
                        state     <= COUNT;
                    end
                end
                COUNT: begin
                    // A count byte of 0 walks the full 256-word range.
                    if (xfer) begin
                        cnt   <= rx_data;
                        sum   <= sum + rx_data;
                        state <= DHI;
                    end
                end
                DHI: begin
                    if (xfer) begin
                        dhi   <= rx_data;
                        sum   <= sum + rx_data;
                        state <= DLO;
                    end
                end
                DLO: begin
                    // Word = {op[4:0], fil[2:0], im[7:0]}; strobe and ready drop together.
                    if (xfer) begin
                        prog_data <= {dhi, rx_data};
                        sum       <= sum + rx_data;
                        prog_we   <= 1'b1;
                        rx_ready  <= 1'b0;
                        state     <= WRITE;
                    end
                end
                WRITE: begin
                    prog_addr <= prog_addr + ADDR_W'(1);
                    cnt       <= cnt - 8'd1;
                    state     <= (cnt == 8'd1) ? CSUM : DHI;
                end
                CSUM: begin
                    if (xfer) begin
                        if (rx_data == sum) begin
                            done <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                        cpu_hold <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: frames driven byte by byte, writes captured off
// the falling edge and compared with hand-computed page/addr/data and status flags.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [1:0]  prog_page;
    logic [7:0]  prog_addr;
    logic [15:0] prog_data;
    logic        prog_we;
    logic        cpu_hold;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    prog_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .prog_page (prog_page),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .prog_we   (prog_we),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .err       (err)
    );

    int          n_pass = 0;
    int          n_total = 0;
    int          ready_bad = 0;
    logic        rst_q = 1'b0;
    logic [25:0] wq[$];

    // Good frame sum: 01+10+02+08+2A+F8+05 = 0x142 -> 0x42.
    logic [7:0] good_body[$] = '{8'h01, 8'h10, 8'h02, 8'h08, 8'h2A, 8'hF8, 8'h05, 8'h42};
    logic [7:0] bad_body[$]  = '{8'h01, 8'h10, 8'h02, 8'h08, 8'h2A, 8'hF8, 8'h05, 8'h3D};
    // Wrap frame sum: 00+FF+02+00+01+00+02 = 0x104 -> 0x04.
    logic [7:0] wrap_body[$] = '{8'h00, 8'hFF, 8'h02, 8'h00, 8'h01, 8'h00, 8'h02, 8'h04};

    always @(posedge clk) rst_q <= rst_n;

    // Capture each write, and check rx_ready is low exactly while prog_we is high.
    always @(negedge clk) begin
        if (prog_we === 1'b1) wq.push_back({prog_page, prog_addr, prog_data});
        if (rst_q && rst_n && (rx_ready !== !prog_we)) ready_bad++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Called at a falling edge; returns at the falling edge after the byte transfers.
    task automatic send(input logic [7:0] b, input int gap);
        int guard;
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        guard    = 0;
        while (rx_ready !== 1'b1 && guard < 16) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 16) chk("ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_list(input logic [7:0] lst[$], input int maxgap);
        foreach (lst[i]) send(lst[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_ready"}, 32'(rx_ready), 32'd0);
        chk({tag, "_page"},  32'(prog_page), 32'd0);
        chk({tag, "_addr"},  32'(prog_addr), 32'd0);
        chk({tag, "_data"},  32'(prog_data), 32'd0);
        chk({tag, "_we"},    32'(prog_we), 32'd0);
        chk({tag, "_hold"},  32'(cpu_hold), 32'd0);
        chk({tag, "_done"},  32'(done), 32'd0);
        chk({tag, "_err"},   32'(err), 32'd0);
    endtask

    task automatic chk_good_writes(input string tag);
        chk({tag, "_nwr"}, 32'(wq.size()), 32'd2);
        chk({tag, "_w0"},  32'((wq.size() > 0) ? wq[0] : 26'h0), 32'({2'd1, 8'h10, 16'h082A}));
        chk({tag, "_w1"},  32'((wq.size() > 1) ? wq[1] : 26'h0), 32'({2'd1, 8'h11, 16'hF805}));
    endtask

    initial begin
        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero_outputs("reset");
        rst_n = 1'b1;

        // Pre-SYNC noise is discarded
        send(8'h00, 0);
        send(8'hFF, 0);
        chk("noise_hold", 32'(cpu_hold), 32'd0);
        chk("noise_nwr", 32'(wq.size()), 32'd0);

        // Good frame
        wq.delete();
        send(8'hA5, 0);
        chk("good_hold_rise", 32'(cpu_hold), 32'd1);
        send_list(good_body, 0);
        chk_good_writes("good");
        chk("good_done", 32'(done), 32'd1);
        chk("good_err", 32'(err), 32'd0);
        chk("good_hold_fall", 32'(cpu_hold), 32'd0);
        chk("good_addr_after", 32'(prog_addr), 32'h12);

        // Bad checksum: writes still land, err flagged
        wq.delete();
        send(8'hA5, 0);
        chk("badcs_done_clr", 32'(done), 32'd0);
        send_list(bad_body, 0);
        chk_good_writes("badcs");
        chk("badcs_err", 32'(err), 32'd1);
        chk("badcs_done", 32'(done), 32'd0);
        chk("badcs_hold", 32'(cpu_hold), 32'd0);

        // Address wrap within page 0
        wq.delete();
        send(8'hA5, 0);
        chk("wrap_err_clr", 32'(err), 32'd0);
        send_list(wrap_body, 0);
        chk("wrap_nwr", 32'(wq.size()), 32'd2);
        chk("wrap_w0", 32'((wq.size() > 0) ? wq[0] : 26'h0), 32'({2'd0, 8'hFF, 16'h0001}));
        chk("wrap_w1", 32'((wq.size() > 1) ? wq[1] : 26'h0), 32'({2'd0, 8'h00, 16'h0002}));
        chk("wrap_done", 32'(done), 32'd1);
        chk("wrap_err", 32'(err), 32'd0);

        // Bad page byte, junk, then recovery frame
        wq.delete();
        send(8'hA5, 0);
        send(8'h04, 0);
        chk("badpg_err", 32'(err), 32'd1);
        chk("badpg_hold", 32'(cpu_hold), 32'd1);
        send(8'h11, 0);
        send(8'h22, 0);
        send(8'h33, 0);
        chk("badpg_junk_err", 32'(err), 32'd1);
        chk("badpg_junk_hold", 32'(cpu_hold), 32'd1);
        chk("badpg_junk_done", 32'(done), 32'd0);
        chk("badpg_junk_nwr", 32'(wq.size()), 32'd0);
        send(8'hA5, 0);
        chk("badpg_resync_err", 32'(err), 32'd0);
        chk("badpg_resync_hold", 32'(cpu_hold), 32'd1);
        send_list(good_body, 0);
        chk_good_writes("recover");
        chk("recover_done", 32'(done), 32'd1);
        chk("recover_hold", 32'(cpu_hold), 32'd0);

        // Throttled frame with random valid gaps
        wq.delete();
        send(8'hA5, 2);
        send_list(good_body, 3);
        chk_good_writes("throttle");
        chk("throttle_done", 32'(done), 32'd1);
        chk("throttle_err", 32'(err), 32'd0);

        // Reset after the DHI byte, then a clean frame
        wq.delete();
        send(8'hA5, 0);
        send(8'h01, 0);
        send(8'h10, 0);
        send(8'h02, 0);
        send(8'h08, 0);
        rst_n = 1'b0;
        @(negedge clk);
        chk_zero_outputs("midrst");
        chk("midrst_nwr", 32'(wq.size()), 32'd0);
        rst_n = 1'b1;
        send(8'hA5, 0);
        send_list(good_body, 0);
        chk_good_writes("postrst");
        chk("postrst_done", 32'(done), 32'd1);
        chk("postrst_err", 32'(err), 32'd0);

        chk("ready_we_exclusive", 32'(ready_bad), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
